// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling and centre-of-bit sampling.
// Status flags RF (full), FE (framing error) and OE (overrun) for a polled consumer.
module uart_receiver #(
    parameter int BAUD_DIV       = 27,
    parameter int STOP_WAIT_HIGH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic       rd_ack,
    output logic [7:0] dout,
    output logic       RF,
    output logic       FE,
    output logic       OE
);
    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q;
    logic          tick;
    logic          rx_meta, rxs;
    logic [3:0]    s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    sh_q, sh_d, dout_d;
    logic          rf_d, fe_d, oe_d;
    logic          wait_q, wait_d;

    assign tick = (tcnt_q == TW'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            tcnt_q  <= '0;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            dout    <= '0;
            RF      <= 1'b0;
            FE      <= 1'b0;
            OE      <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
            tcnt_q  <= tick ? '0 : tcnt_q + TW'(1);
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            dout    <= dout_d;
            RF      <= rf_d;
            FE      <= fe_d;
            OE      <= oe_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        dout_d  = dout;
        rf_d    = RF;
        fe_d    = FE;
        oe_d    = OE;
        wait_d  = wait_q;

        if (rd_ack) begin
            rf_d = 1'b0;
            oe_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        s_d = '0;
                        n_d = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d  = '0;
                        sh_d = {rxs, sh_q[7:1]};
                        if (n_q == 3'd7) state_d = STOP;
                        else             n_d = n_q + 3'd1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (wait_q) begin
                        // line must stay high a full bit time before re-arming
                        if (!rxs) begin
                            s_d = '0;
                        end else if (s_q == 4'd15) begin
                            s_d     = '0;
                            wait_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            s_d = s_q + 4'd1;
                        end
                    end else if (s_q == 4'd15) begin
                        s_d = '0;
                        if (rxs) begin
                            dout_d  = sh_q;
                            fe_d    = 1'b0;
                            rf_d    = 1'b1;
                            if (RF && !rd_ack) oe_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            fe_d = 1'b1;
                            if (STOP_WAIT_HIGH != 0) wait_d  = 1'b1;
                            else                     state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
        endcase
    end
endmodule
